// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch (if_*) and
//               the load/store path (dm_*). One transaction in flight at a
//               time. The winning command is latched and held on mem_* until
//               mem_ack. The read data then returns to the owning requester
//               as a one-cycle rvalid pulse.
//
// Ports       : clock, reset_n            clock / async active-low reset
//               if_req/if_addr            fetch request (held until if_gnt)
//               if_gnt/if_rvalid/if_rdata fetch grant and response
//               dm_req/addr/we/size/wdata data request (held until dm_gnt)
//               dm_gnt/dm_rvalid/dm_rdata data grant and response
//                                         (dm_rdata = 0 for stores)
//               mem_req/addr/we/size/wdata registered memory command
//               mem_ack/mem_rdata         memory completion and read data
//               busy                      high whenever not IDLE
//
// Options     : ARB_ROUND_ROBIN_EN - when defined, a contention goes to the
//               requester that was not the last owner. Otherwise dm always
//               has priority.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic                  dm_we,
    input  logic [1:0]            dm_size,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [1:0]            mem_size,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic       c_OWNER_IF  = 1'b0;
    localparam logic       c_OWNER_DM  = 1'b1;
    localparam logic [1:0] c_SIZE_WORD = 2'd3;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [1:0]            r_size;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_dm_wins;
    logic                  w_grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_owner;

    // A lone request always wins. On contention, the side that did not own
    // the previous grant wins. Reset value is fetch, so dm wins the first tie.
    assign w_dm_wins = dm_req & (~if_req | (r_last_owner == c_OWNER_IF));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_owner <= c_OWNER_IF;
        end else if (w_grant) begin
            r_last_owner <= w_dm_wins ? c_OWNER_DM : c_OWNER_IF;
        end
    end
`else
    // Fixed priority: dm wins every contention.
    assign w_dm_wins = dm_req;
`endif

    assign w_grant = (r_state == IDLE) & (if_req | dm_req);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and outputs
    always_comb begin
        w_next_state = r_state;
        if_gnt       = 1'b0;
        dm_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        dm_rvalid    = 1'b0;
        if_rdata     = '0;
        dm_rdata     = '0;
        mem_req      = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy   = 1'b0;
                dm_gnt = w_dm_wins;
                if_gnt = if_req & ~w_dm_wins;
                if (w_grant) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (r_owner == c_OWNER_DM) begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = r_rdata;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = r_rdata;
                end
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Command latch and response register. The mem_* outputs come straight
    // from these registers so they stay stable for the whole ACCESS phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= c_OWNER_IF;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_size  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_grant) begin
                if (w_dm_wins) begin
                    r_owner <= c_OWNER_DM;
                    r_addr  <= dm_addr;
                    r_we    <= dm_we;
                    r_size  <= dm_size;
                    r_wdata <= dm_wdata;
                end else begin
                    // A fetch is always a word read.
                    r_owner <= c_OWNER_IF;
                    r_addr  <= if_addr;
                    r_we    <= 1'b0;
                    r_size  <= c_SIZE_WORD;
                    r_wdata <= '0;
                end
            end
            if ((r_state == ACCESS) && mem_ack) begin
                r_rdata <= r_we ? '0 : mem_rdata;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_we    = r_we;
    assign mem_size  = r_size;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed testbench for mem_port_arbiter. The expected
//               responses (owner, data) are queued when a transaction is
//               issued. A negedge monitor pops and compares them whenever
//               an rvalid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [1:0]    dm_size;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_req, mem_we, mem_ack, busy;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_size;
    logic [DW-1:0] mem_wdata, mem_rdata;

    typedef struct packed {
        logic          owner;   // 0 = fetch, 1 = dm
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_addr   (dm_addr),
        .dm_we     (dm_we),
        .dm_size   (dm_size),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Grant/rvalid/busy/mem_req packed as {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, busy}
    function automatic logic [31:0] ctl();
        return {26'd0, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, busy};
    endfunction

    // Response monitor: every rvalid must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset_n && (if_rvalid || dm_rvalid)) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rvalid_owner", {30'd0, if_rvalid, dm_rvalid}, e.owner ? 32'd1 : 32'd2);
                chk("rdata_owner", e.owner ? dm_rdata : if_rdata, e.data);
                chk("rdata_nonowner", e.owner ? if_rdata : dm_rdata, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_if;
        reset_n   = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_addr   = '0;
        dm_we     = 1'b0;
        dm_size   = '0;
        dm_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clock);
        chk("rst_ctl", ctl(), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_cmd", {29'd0, mem_we, mem_size}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        step();
        reset_n = 1'b1;

        // ---------------- reset mid-ACCESS ----------------
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        @(negedge clock);
        chk("rm_if_gnt", ctl(), 32'b100000);
        step();
        if_req = 1'b0;
        @(negedge clock);
        chk("rm_access", ctl(), 32'b000011);
        chk("rm_addr", mem_addr, 32'h10);
        #1 reset_n = 1'b0;
        #1;
        chk("rm_async_ctl", ctl(), 32'd0);
        chk("rm_async_addr", mem_addr, 32'd0);
        step();
        reset_n = 1'b1;
        @(negedge clock);
        chk("rm_after_ctl", ctl(), 32'd0);
        step();
        @(negedge clock);
        chk("rm_after2_ctl", ctl(), 32'd0);

        // ---------------- contention, both held, 1-cycle ack ----------------
        step();
        if_req    = 1'b1;
        if_addr   = 32'h0000_0300;
        dm_req    = 1'b1;
        dm_addr   = 32'h0000_0200;
        dm_we     = 1'b0;
        dm_size   = 2'd3;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) step();
            if (c == 7) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            @(negedge clock);
`ifdef ARB_ROUND_ROBIN_EN
            exp_if = (c == 3);
`else
            exp_if = 1'b0;
`endif
            if (c % 3 == 0) begin
                chk($sformatf("cont_gnt_c%0d", c), {30'd0, if_gnt, dm_gnt},
                    exp_if ? 32'd2 : 32'd1);
                sb.push_back('{owner: ~exp_if, data: 32'h1234_5678});
            end else begin
                chk($sformatf("cont_nogn_c%0d", c), {30'd0, if_gnt, dm_gnt}, 32'd0);
            end
        end
        step();
        mem_ack = 1'b0;
        @(negedge clock);
        chk("cont_done_ctl", ctl(), 32'd0);

        // ---------------- lone fetch, ack in cycle 3 ----------------
        step();
        if_req  = 1'b1;
        if_addr = 32'h0000_0004;
        @(negedge clock);
        chk("lf_gnt", ctl(), 32'b100000);
        for (int c = 1; c <= 3; c++) begin
            step();
            if_req = 1'b0;
            if (c == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h0051_3023;
                sb.push_back('{owner: 1'b0, data: 32'h0051_3023});
            end
            @(negedge clock);
            chk($sformatf("lf_ctl_c%0d", c), ctl(), 32'b000011);
            chk($sformatf("lf_addr_c%0d", c), mem_addr, 32'h4);
            chk($sformatf("lf_cmd_c%0d", c), {29'd0, mem_we, mem_size}, 32'd3);
        end
        step();
        mem_ack = 1'b0;
        @(negedge clock);
        chk("lf_rvalid", ctl(), 32'b001001);
        chk("lf_rdata", if_rdata, 32'h0051_3023);
        step();
        @(negedge clock);
        chk("lf_idle", ctl(), 32'd0);

        // ---------------- byte store, ack in cycle 1 ----------------
        step();
        dm_req   = 1'b1;
        dm_addr  = 32'h0000_0100;
        dm_we    = 1'b1;
        dm_size  = 2'd0;
        dm_wdata = 32'h0000_00AB;
        @(negedge clock);
        chk("st_gnt", ctl(), 32'b010000);
        step();
        dm_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        sb.push_back('{owner: 1'b1, data: 32'd0});
        @(negedge clock);
        chk("st_cmd", {29'd0, mem_we, mem_size}, 32'b100);
        chk("st_addr", mem_addr, 32'h100);
        chk("st_wdata", mem_wdata, 32'hAB);
        // ack with all-ones data during RESP and then IDLE must be ignored
        step();
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        chk("st_rvalid", ctl(), 32'b000101);
        chk("st_rdata", dm_rdata, 32'd0);
        step();
        @(negedge clock);
        chk("ack_idle_ctl", ctl(), 32'd0);
        step();
        mem_ack = 1'b0;
        @(negedge clock);
        chk("ack_idle2_ctl", ctl(), 32'd0);
        step();
        @(negedge clock);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
